fp32_mant_normalizer: RTL and testbench

//  Sequential post-add normaliser for the FP32 add/sub datapath. Input is the raw mantissa and

---
 rtl/fp32_mant_normalizer_if.sv | 25 ++
 rtl/fp32_mant_normalizer.sv | 80 ++++++++
 tb/tb_fp32_mant_normalizer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fp32_mant_normalizer_if.sv
// fp32_mant_normalizer_if: input/output handshake bundle for the post-add normaliser
interface fp32_mant_normalizer_if #(
  parameter int MANT_W = 27,
  parameter int EXP_W  = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [EXP_W-1:0]  i_exp;
  logic [MANT_W:0]   i_mant;
  logic              o_valid;
  logic              i_ready;
  logic [EXP_W-1:0]  o_exp;
  logic [MANT_W-1:0] o_mant;
  logic              o_zero;
  logic              o_denorm;
  logic              o_ovf;
  modport slave (
    input  i_valid, i_exp, i_mant, i_ready,
    output o_ready, o_valid, o_exp, o_mant, o_zero, o_denorm, o_ovf
  );
  modport master (
    output i_valid, i_exp, i_mant, i_ready,
    input  o_ready, o_valid, o_exp, o_mant, o_zero, o_denorm, o_ovf
  );
endinterface

// File: rtl/fp32_mant_normalizer.sv
// fp32_mant_normalizer: sequential one-bit-per-cycle renormaliser after the FP32 mantissa add
module fp32_mant_normalizer #(
  parameter int MANT_W = 27,
  parameter int EXP_W  = 8
) (
  input logic i_clk,
  input logic i_rst,
  fp32_mant_normalizer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  state_t state, state_n;
  logic [MANT_W-1:0] m, m_l, m_r;
  logic [EXP_W-1:0] e, e_in, e_d;
  logic [EXP_W:0] e_inc;
  logic zero, denorm, ovf, acc, in_zero, in_carry, in_msb, in_low, ovf_in, sh_msb, sh_low;
  always_comb begin
    acc      = bus.i_valid && state == IDLE;
    e_in     = (bus.i_exp == '0) ? EXP_W'(1) : bus.i_exp;
    e_inc    = {1'b0, e_in} + 1'b1;
    ovf_in   = e_inc >= EMAX;
    in_zero  = bus.i_mant == '0;
    in_carry = bus.i_mant[MANT_W];
    in_msb   = bus.i_mant[MANT_W-1];
    in_low   = e_in == EXP_W'(1);
    m_r      = {bus.i_mant[MANT_W:2], bus.i_mant[1] | bus.i_mant[0]};
    m_l      = {m[MANT_W-2:0], 1'b0};
    e_d      = e - 1'b1;
    sh_msb   = m_l[MANT_W-1];
    sh_low   = e_d == EXP_W'(1);
  end
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !acc ? IDLE : (in_zero || in_carry || in_msb || in_low) ? DONE : SHIFT;
      SHIFT:   state_n = (sh_msb || sh_low) ? DONE : SHIFT;
      DONE:    state_n = bus.i_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.o_ready  = state == IDLE;
    bus.o_valid  = state == DONE;
    bus.o_exp    = e;
    bus.o_mant   = m;
    bus.o_zero   = zero;
    bus.o_denorm = denorm;
    bus.o_ovf    = ovf;
  end
  // Classification priority at accept: zero, carry, already normal, underflow floor, else shift.
  always_ff @(posedge i_clk)
    if (i_rst) begin
      m      <= '0;
      e      <= '0;
      zero   <= 1'b0;
      denorm <= 1'b0;
      ovf    <= 1'b0;
    end else if (acc) begin
      zero   <= in_zero;
      ovf    <= !in_zero && in_carry && ovf_in;
      denorm <= !in_zero && !in_carry && !in_msb && in_low;
      if (in_zero) begin
        m <= '0;
        e <= '0;
      end else if (in_carry) begin
        m <= ovf_in ? '0 : m_r;
        e <= ovf_in ? {EXP_W{1'b1}} : e_inc[EXP_W-1:0];
      end else begin
        m <= bus.i_mant[MANT_W-1:0];
        e <= (!in_msb && in_low) ? '0 : e_in;
      end
    end else if (state == SHIFT) begin
      m      <= m_l;
      e      <= (!sh_msb && sh_low) ? '0 : e_d;
      denorm <= !sh_msb && sh_low;
    end
endmodule

// File: tb/tb_fp32_mant_normalizer.sv
// tb_fp32_mant_normalizer: directed-vector checks of the post-add normaliser
module tb_fp32_mant_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  fp32_mant_normalizer_if #(.MANT_W(27), .EXP_W(8)) bus ();
  fp32_mant_normalizer #(.MANT_W(27), .EXP_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  int lat;
  logic [7:0] oe;
  logic [26:0] om;
  logic [2:0] fl;

  task automatic run_op(input logic [27:0] mant, input logic [7:0] exp);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_mant = mant;
    bus.i_exp = exp;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!bus.o_valid) lat = -1;
    oe = bus.o_exp;
    om = bus.o_mant;
    fl = {bus.o_zero, bus.o_denorm, bus.o_ovf};
  endtask

  task automatic accept();
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    checks++; if ({bus.o_exp, bus.o_mant} !== 35'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.o_exp, bus.o_mant}); end
    checks++; if ({bus.o_zero, bus.o_denorm, bus.o_ovf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.o_zero, bus.o_denorm, bus.o_ovf}); end
  endtask

  task automatic test_vector(input string name, input logic [27:0] mant, input logic [7:0] exp,
                             input int xlat, input logic [7:0] xe, input logic [26:0] xm, input logic [2:0] xf);
    run_op(mant, exp);
    checks++; if (lat !== xlat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, xlat); end
    checks++; if (oe !== xe) begin failures++; $display("FAIL %s_exp got=%0d exp=%0d", name, oe, xe); end
    checks++; if (om !== xm) begin failures++; $display("FAIL %s_mant got=%h exp=%h", name, om, xm); end
    checks++; if (fl !== xf) begin failures++; $display("FAIL %s_flags(zdo) got=%b exp=%b", name, fl, xf); end
    accept();
    checks++; if ({bus.o_valid, bus.o_ready} !== 2'b01) begin failures++; $display("FAIL %s_release got=%b exp=01", name, {bus.o_valid, bus.o_ready}); end
  endtask

  task automatic test_hold();
    run_op(28'h0000400, 8'd100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_mant = 28'h0000001;
      bus.i_exp = 8'd9;
      @(posedge clk);
      #1;
      checks++; if ({bus.o_valid, bus.o_ready} !== 2'b10) begin failures++; $display("FAIL hold_hs%0d got=%b exp=10", i, {bus.o_valid, bus.o_ready}); end
      checks++; if ({bus.o_exp, bus.o_mant} !== {8'd84, 27'h4000000}) begin failures++; $display("FAIL hold_data%0d got=%h exp=%h", i, {bus.o_exp, bus.o_mant}, {8'd84, 27'h4000000}); end
    end
    @(negedge clk) bus.i_valid = 1'b0;
    accept();
    checks++; if ({bus.o_valid, bus.o_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b exp=01", {bus.o_valid, bus.o_ready}); end
    lat = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (bus.o_valid) lat++;
    end
    checks++; if (lat !== 0) begin failures++; $display("FAIL hold_ignored got=%0d valid_cycles exp=0", lat); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_mant = 28'h0000400;
    bus.i_exp = 8'd100;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({bus.o_valid, bus.o_ready} !== 2'b01) begin failures++; $display("FAIL midrst_hs got=%b exp=01", {bus.o_valid, bus.o_ready}); end
    @(negedge clk) rst = 1'b0;
    lat = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (bus.o_valid) lat++;
    end
    checks++; if (lat !== 0) begin failures++; $display("FAIL midrst_no_result got=%0d valid_cycles exp=0", lat); end
  endtask

  task automatic test_back_to_back();
    run_op(28'h4000000, 8'd50);
    checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=1", lat); end
    accept();
    run_op(28'h1000000, 8'd50);
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=3", lat); end
    checks++; if ({oe, om} !== {8'd48, 27'h4000000}) begin failures++; $display("FAIL b2b_second_data got=%h exp=%h", {oe, om}, {8'd48, 27'h4000000}); end
    accept();
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_mant = '0;
    bus.i_exp = '0;
    test_reset();
    test_vector("normal",  28'h4000000, 8'd100, 1,  8'd100, 27'h4000000, 3'b000);
    test_vector("carry",   28'h8000003, 8'd100, 1,  8'd101, 27'h4000001, 3'b000);
    test_vector("shift16", 28'h0000400, 8'd100, 17, 8'd84,  27'h4000000, 3'b000);
    test_vector("denorm",  28'h0000400, 8'd5,   5,  8'd0,   27'h0004000, 3'b010);
    test_vector("zero",    28'h0000000, 8'd77,  1,  8'd0,   27'h0000000, 3'b100);
    test_vector("ovf",     28'h8000000, 8'd254, 1,  8'd255, 27'h0000000, 3'b001);
    test_vector("nearovf", 28'h8000001, 8'd253, 1,  8'd254, 27'h4000001, 3'b000);
    test_vector("exp0",    28'h2000000, 8'd0,   1,  8'd0,   27'h2000000, 3'b010);
    test_vector("maxk",    28'h0000001, 8'd200, 27, 8'd174, 27'h4000000, 3'b000);
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
